// File: rtl/atm_pkg.sv
// Shared types for the ATM transaction controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package atm_pkg;

  // FSM state codes; current_state exposes these directly, codes 9-15 are illegal.
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    LANG     = 4'd1,
    PASS     = 4'd2,
    MENU     = 4'd3,
    DEPOSIT  = 4'd4,
    BALANCE  = 4'd5,
    WITHDRAW = 4'd6,
    CONFIRM  = 4'd7,
    AGAIN    = 4'd8
  } state_t;

  // Front-panel operation selector encoding.
  localparam logic [1:0] OP_DEP  = 2'b00;
  localparam logic [1:0] OP_BAL  = 2'b01;
  localparam logic [1:0] OP_WD   = 2'b10;
  localparam logic [1:0] OP_EXIT = 2'b11;

  // Pending transaction kind held between selection and confirmation.
  typedef enum logic [1:0] {
    TXN_DEP = 2'd0,
    TXN_CHK = 2'd1,
    TXN_WD  = 2'd2
  } txn_t;

  // Width of the front-panel amount field.
  localparam int AMT_W = 7;

endpackage

// File: rtl/atm_fsm_ledger.sv
// Account ledger: balance register, pending amount/op, and overflow/shortfall compares.
// Latency: compares are combinational on the live balance; commit updates balance next edge.
// Backpressure: none; latch/commit strobes are acted on in the cycle they are high.
module atm_ledger
  import atm_pkg::*;
#(
  parameter int BAL_W        = 10,
  parameter int INIT_BALANCE = 100
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [AMT_W-1:0] amount,
  input  logic             amt_en,
  input  logic             op_en,
  input  txn_t             op,
  input  logic             commit,
  output logic [BAL_W-1:0] balance,
  output logic             dep_ovf,
  output logic             wd_short
);

  logic [BAL_W-1:0] bal_q;
  logic [BAL_W-1:0] bal_d;
  logic [BAL_W-1:0] pend_q;
  logic [BAL_W-1:0] amt_ext;
  logic [BAL_W:0]   dep_sum;
  txn_t             op_q;

  assign amt_ext = {{(BAL_W-AMT_W){1'b0}}, amount};

  // One extra bit on the sum catches a deposit that would wrap the balance.
  assign dep_sum  = {1'b0, bal_q} + {1'b0, amt_ext};
  assign dep_ovf  = dep_sum[BAL_W];
  assign wd_short = (amt_ext > bal_q);
  assign balance  = bal_q;

  // Apply the pending transaction only on a confirmed commit; a check leaves it alone.
  always_comb begin
    bal_d = bal_q;
    if (commit) begin
      case (op_q)
        TXN_DEP: bal_d = bal_q + pend_q;
        TXN_WD:  bal_d = bal_q - pend_q;
        default: bal_d = bal_q;
      endcase
    end
  end

  // Balance, pending amount and pending op registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bal_q  <= BAL_W'(INIT_BALANCE);
      pend_q <= '0;
      op_q   <= TXN_CHK;
    end else begin
      bal_q <= bal_d;
      if (amt_en) pend_q <= amt_ext;
      if (op_en)  op_q   <= op;
    end
  end

endmodule

// File: rtl/atm_fsm.sv
// ATM session controller: card, language, PIN, then deposit/check/withdraw with confirm.
// Latency: one state per clock; status pulses appear the cycle after the deciding state.
// Backpressure: none; front-panel inputs are sampled every rising edge.
module atm_fsm
  import atm_pkg::*;
#(
  parameter logic [3:0] PIN          = 4'b0110,
  parameter int         BAL_W        = 10,
  parameter int         INIT_BALANCE = 100
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             incard,
  input  logic             language,
  input  logic [3:0]       password,
  input  logic [1:0]       operations,
  input  logic [AMT_W-1:0] amount,
  input  logic             confirm,
  input  logic             again,
  output logic             incorrectpswd,
  output logic             nobalance,
  output logic             success,
  output logic [3:0]       current_state,
  output logic [BAL_W-1:0] balance,
  output logic             lang_sel
);

  state_t state_q;
  state_t state_d;
  logic   lang_q;
  logic   lang_d;
  logic   incorrect_d;
  logic   nobal_d;
  logic   success_d;
  logic   amt_en;
  logic   op_en;
  txn_t   op_sel;
  logic   commit;
  logic   dep_ovf;
  logic   wd_short;

  atm_ledger #(
    .BAL_W        (BAL_W),
    .INIT_BALANCE (INIT_BALANCE)
  ) u_ledger (
    .clock    (clock),
    .reset_n  (reset_n),
    .amount   (amount),
    .amt_en   (amt_en),
    .op_en    (op_en),
    .op       (op_sel),
    .commit   (commit),
    .balance  (balance),
    .dep_ovf  (dep_ovf),
    .wd_short (wd_short)
  );

  // Next-state, ledger strobes and next pulse values; illegal codes fall back to IDLE.
  always_comb begin
    state_d     = state_q;
    lang_d      = lang_q;
    incorrect_d = 1'b0;
    nobal_d     = 1'b0;
    success_d   = 1'b0;
    amt_en      = 1'b0;
    op_en       = 1'b0;
    op_sel      = TXN_CHK;
    commit      = 1'b0;
    case (state_q)
      IDLE: begin
        if (incard) state_d = LANG;
      end
      LANG: begin
        lang_d  = language;
        state_d = PASS;
      end
      PASS: begin
        if (password == PIN) begin
          state_d = MENU;
        end else begin
          incorrect_d = 1'b1;
          state_d     = IDLE;
        end
      end
      MENU: begin
        case (operations)
          OP_DEP:  state_d = DEPOSIT;
          OP_BAL:  state_d = BALANCE;
          OP_WD:   state_d = WITHDRAW;
          default: state_d = IDLE;
        endcase
      end
      DEPOSIT: begin
        // A deposit that would overflow is dropped silently.
        if (dep_ovf) begin
          state_d = AGAIN;
        end else begin
          amt_en  = 1'b1;
          op_en   = 1'b1;
          op_sel  = TXN_DEP;
          state_d = CONFIRM;
        end
      end
      BALANCE: begin
        op_en   = 1'b1;
        op_sel  = TXN_CHK;
        state_d = CONFIRM;
      end
      WITHDRAW: begin
        amt_en = 1'b1;
        if (wd_short) begin
          nobal_d = 1'b1;
          state_d = AGAIN;
        end else begin
          op_en   = 1'b1;
          op_sel  = TXN_WD;
          state_d = CONFIRM;
        end
      end
      CONFIRM: begin
        if (confirm) begin
          commit    = 1'b1;
          success_d = 1'b1;
        end
        state_d = AGAIN;
      end
      AGAIN: begin
        state_d = again ? MENU : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched language and registered one-cycle status pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      lang_q        <= 1'b0;
      incorrectpswd <= 1'b0;
      nobalance     <= 1'b0;
      success       <= 1'b0;
    end else begin
      state_q       <= state_d;
      lang_q        <= lang_d;
      incorrectpswd <= incorrect_d;
      nobalance     <= nobal_d;
      success       <= success_d;
    end
  end

  assign current_state = state_q;
  assign lang_sel      = lang_q;

endmodule

// File: tb/tb_atm_fsm.sv
// Directed-vector bench for atm_fsm with a pulse scoreboard.
// Latency: stimulus advances one clock per step; pulses checked at the falling edge.
// Backpressure: n/a.
module tb_atm_fsm;

  localparam logic [2:0] K_INC = 3'b100;
  localparam logic [2:0] K_NOB = 3'b010;
  localparam logic [2:0] K_SUC = 3'b001;

  typedef struct packed {
    logic [2:0] kind;
    logic [9:0] bal;
  } exp_t;

  logic       clock;
  logic       reset_n;
  logic       incard;
  logic       language;
  logic [3:0] password;
  logic [1:0] operations;
  logic [6:0] amount;
  logic       confirm;
  logic       again;
  logic       incorrectpswd;
  logic       nobalance;
  logic       success;
  logic [3:0] current_state;
  logic [9:0] balance;
  logic       lang_sel;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  atm_fsm #(
    .PIN          (4'b0110),
    .BAL_W        (10),
    .INIT_BALANCE (100)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .incard        (incard),
    .language      (language),
    .password      (password),
    .operations    (operations),
    .amount        (amount),
    .confirm       (confirm),
    .again         (again),
    .incorrectpswd (incorrectpswd),
    .nobalance     (nobalance),
    .success       (success),
    .current_state (current_state),
    .balance       (balance),
    .lang_sel      (lang_sel)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_pulse(input logic [2:0] kind, input logic [9:0] bal);
    exp_t e;
    e.kind = kind;
    e.bal  = bal;
    exp_q.push_back(e);
  endtask

  // Monitor: every observed pulse must match the oldest expected event.
  always @(negedge clock) begin
    logic [2:0] seen;
    exp_t       e;
    seen = {incorrectpswd, nobalance, success};
    if (seen != 3'b000) begin
      if (exp_q.size() == 0) begin
        check("unexpected pulse", 32'(seen), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse kind", 32'(seen), 32'(e.kind));
        check("pulse balance", 32'(balance), 32'(e.bal));
      end
    end
  end

  // Hard stop if the directed sequence never reaches its end.
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n    = 1'b0;
    incard     = 1'b0;
    language   = 1'b0;
    password   = 4'd0;
    operations = 2'b00;
    amount     = 7'd0;
    confirm    = 1'b0;
    again      = 1'b0;
    #12;
    check("reset state", 32'(current_state), 32'd0);
    check("reset balance", 32'(balance), 32'd100);
    check("reset lang", 32'(lang_sel), 32'd0);
    check("reset pulses", 32'({incorrectpswd, nobalance, success}), 32'd0);
    reset_n = 1'b1;

    // Wrong PIN: 0 -> 1 -> 2 -> 0 with a single incorrectpswd pulse.
    incard = 1'b1; language = 1'b1; password = 4'b0011;
    tick(); check("badpin LANG", 32'(current_state), 32'd1);
    tick(); check("badpin PASS", 32'(current_state), 32'd2);
    check("lang latched", 32'(lang_sel), 32'd1);
    expect_pulse(K_INC, 10'd100);
    tick(); check("badpin IDLE", 32'(current_state), 32'd0);
    incard = 1'b0;
    tick(); check("idle holds", 32'(current_state), 32'd0);

    // Good PIN, deposit 74 confirmed, go again.
    incard = 1'b1; language = 1'b0; password = 4'b0110;
    tick(); tick();
    check("lang relatched", 32'(lang_sel), 32'd0);
    tick(); check("goodpin MENU", 32'(current_state), 32'd3);
    incard = 1'b0; operations = 2'b00;
    tick(); check("DEPOSIT", 32'(current_state), 32'd4);
    amount = 7'd74;
    tick(); check("dep CONFIRM", 32'(current_state), 32'd7);
    confirm = 1'b1;
    expect_pulse(K_SUC, 10'd174);
    tick(); check("dep AGAIN", 32'(current_state), 32'd8);
    check("dep balance", 32'(balance), 32'd174);
    again = 1'b1;
    tick(); check("again MENU", 32'(current_state), 32'd3);

    // Balance check confirmed.
    operations = 2'b01;
    tick(); check("BALANCE", 32'(current_state), 32'd5);
    tick();
    expect_pulse(K_SUC, 10'd174);
    tick(); check("chk balance", 32'(balance), 32'd174);
    tick(); check("chk MENU", 32'(current_state), 32'd3);

    // Withdraw 51, then finish.
    operations = 2'b10;
    tick(); check("WITHDRAW", 32'(current_state), 32'd6);
    amount = 7'd51;
    tick();
    expect_pulse(K_SUC, 10'd123);
    tick();
    again = 1'b0;
    tick(); check("wd IDLE", 32'(current_state), 32'd0);
    check("wd balance", 32'(balance), 32'd123);

    // New session, card pulled mid-session, withdraw 127 > 123.
    incard = 1'b1;
    tick(); tick(); tick();
    incard = 1'b0;
    operations = 2'b10;
    tick(); check("short WITHDRAW", 32'(current_state), 32'd6);
    amount = 7'd127;
    expect_pulse(K_NOB, 10'd123);
    tick(); check("short AGAIN", 32'(current_state), 32'd8);
    check("short balance", 32'(balance), 32'd123);

    // Cancelled deposit leaves balance alone and raises no pulse.
    again = 1'b1; operations = 2'b00; amount = 7'd10; confirm = 1'b0;
    tick(); tick(); tick();
    check("cancel CONFIRM", 32'(current_state), 32'd7);
    tick(); check("cancel AGAIN", 32'(current_state), 32'd8);
    check("cancel balance", 32'(balance), 32'd123);

    // Asynchronous reset in the middle of a withdraw.
    operations = 2'b10;
    tick(); tick(); check("pre-reset WITHDRAW", 32'(current_state), 32'd6);
    #2 reset_n = 1'b0;
    #1;
    check("async reset state", 32'(current_state), 32'd0);
    check("async reset balance", 32'(balance), 32'd100);
    @(negedge clock) reset_n = 1'b1;

    // Withdraw exactly the full balance.
    incard = 1'b1; confirm = 1'b1; amount = 7'd100; again = 1'b0;
    tick(); tick(); tick();
    incard = 1'b0;
    tick(); check("full WITHDRAW", 32'(current_state), 32'd6);
    tick(); check("full CONFIRM", 32'(current_state), 32'd7);
    expect_pulse(K_SUC, 10'd0);
    tick(); check("full balance", 32'(balance), 32'd0);
    tick(); check("full IDLE", 32'(current_state), 32'd0);

    // Exit from the menu goes straight back to IDLE.
    incard = 1'b1; operations = 2'b11;
    tick(); tick(); tick();
    incard = 1'b0;
    tick(); check("exit IDLE", 32'(current_state), 32'd0);

    tick(); tick();
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
